// File: rtl/race_sequencer.sv
// Race flow controller: IDLE -> COUNTDOWN -> RACING -> FINISH, with lap counting, winner and race timer.
// All outputs registered, one cycle from event to output; no flow control, start is a one-cycle pulse.
module race_sequencer #(
  parameter int unsigned TICKS_PER_SEC = 100000000,
  parameter int unsigned LAPS          = 3,
  parameter int unsigned FIN_X0        = 10,
  parameter int unsigned FIN_X1        = 30,
  parameter int unsigned FIN_Y0        = 115,
  parameter int unsigned FIN_Y1        = 135,
  parameter int unsigned CHK_X0        = 150,
  parameter int unsigned CHK_X1        = 170,
  parameter int unsigned CHK_Y0        = 20,
  parameter int unsigned CHK_Y1        = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [9:0] p1_x,
  input  logic [9:0] p1_y,
  input  logic [9:0] p2_x,
  input  logic [9:0] p2_y,
  output logic [2:0] state,
  output logic [1:0] countdown,
  output logic [2:0] p1_lap,
  output logic [2:0] p2_lap,
  output logic [1:0] winner,
  output logic [9:0] race_sec
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CD   = 3'd1;
  localparam logic [2:0] S_RACE = 3'd4;
  localparam logic [2:0] S_FIN  = 3'd5;

  localparam int unsigned   TW       = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [TW-1:0] TICK_MAX = TW'(TICKS_PER_SEC - 1);
  localparam logic [2:0]    LAPS_L   = 3'(LAPS);
  localparam logic [9:0]    FX0 = 10'(FIN_X0), FX1 = 10'(FIN_X1), FY0 = 10'(FIN_Y0), FY1 = 10'(FIN_Y1);
  localparam logic [9:0]    CX0 = 10'(CHK_X0), CX1 = 10'(CHK_X1), CY0 = 10'(CHK_Y0), CY1 = 10'(CHK_Y1);

  logic [2:0]    state_q, state_d;
  logic [1:0]    cd_q, cd_d;
  logic [2:0]    l1_q, l1_d, l2_q, l2_d;
  logic [1:0]    win_q, win_d;
  logic [9:0]    sec_q, sec_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic          chk1_q, chk1_d, chk2_q, chk2_d;
  logic          fin1_q, fin1_d, fin2_q, fin2_d;
  logic          tick, clr_all, lap1_ev, lap2_ev, done1, done2;
  logic          in_fin1, in_fin2, in_chk1, in_chk2;

  function automatic logic in_box(input logic [9:0] x, input logic [9:0] y,
                                  input logic [9:0] x0, input logic [9:0] x1,
                                  input logic [9:0] y0, input logic [9:0] y1);
    return (x >= x0) && (x <= x1) && (y >= y0) && (y <= y1);
  endfunction

  assign in_fin1 = in_box(p1_x, p1_y, FX0, FX1, FY0, FY1);
  assign in_fin2 = in_box(p2_x, p2_y, FX0, FX1, FY0, FY1);
  assign in_chk1 = in_box(p1_x, p1_y, CX0, CX1, CY0, CY1);
  assign in_chk2 = in_box(p2_x, p2_y, CX0, CX1, CY0, CY1);
  assign tick    = (tick_cnt_q == TICK_MAX);

  always_comb begin
    state_d = state_q;
    cd_d    = cd_q;
    l1_d    = l1_q;
    l2_d    = l2_q;
    win_d   = win_q;
    sec_d   = sec_q;
    chk1_d  = chk1_q;
    chk2_d  = chk2_q;
    fin1_d  = fin1_q;
    fin2_d  = fin2_q;
    clr_all = 1'b0;
    lap1_ev = 1'b0;
    lap2_ev = 1'b0;
    done1   = 1'b0;
    done2   = 1'b0;

    case (state_q)
      S_IDLE: begin
        clr_all = 1'b1;
        if (start) state_d = S_CD;
      end
      S_CD: begin
        if (tick) begin
          if (cd_q == 2'd1) begin
            state_d = S_RACE;
            cd_d    = 2'd0;
            fin1_d  = 1'b0;
            fin2_d  = 1'b0;
          end else begin
            cd_d = cd_q - 2'd1;
          end
        end
      end
      S_RACE: begin
        if (tick && sec_q != 10'd999) sec_d = sec_q + 10'd1;
        // A lap needs a fresh entry into the finish box after touching the checkpoint.
        lap1_ev = in_fin1 && !fin1_q && chk1_q && (l1_q != LAPS_L);
        lap2_ev = in_fin2 && !fin2_q && chk2_q && (l2_q != LAPS_L);
        fin1_d  = in_fin1;
        fin2_d  = in_fin2;
        chk1_d  = lap1_ev ? 1'b0 : (chk1_q | in_chk1);
        chk2_d  = lap2_ev ? 1'b0 : (chk2_q | in_chk2);
        l1_d    = l1_q + {2'b00, lap1_ev};
        l2_d    = l2_q + {2'b00, lap2_ev};
        done1   = (l1_d == LAPS_L);
        done2   = (l2_d == LAPS_L);
        if (done1 && done2) win_d = 2'd3;
        else if (done1)     win_d = 2'd1;
        else if (done2)     win_d = 2'd2;
        if (win_d != 2'd0) state_d = S_FIN;
      end
      S_FIN: begin
        if (start) begin
          state_d = S_IDLE;
          clr_all = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        clr_all = 1'b1;
      end
    endcase

    if (clr_all) begin
      cd_d   = (state_d == S_CD) ? 2'd3 : 2'd0;
      l1_d   = 3'd0;
      l2_d   = 3'd0;
      win_d  = 2'd0;
      sec_d  = 10'd0;
      chk1_d = 1'b0;
      chk2_d = 1'b0;
      fin1_d = 1'b0;
      fin2_d = 1'b0;
    end

    // Every state entry restarts the second timebase.
    if (state_d != state_q || tick) tick_cnt_d = '0;
    else                            tick_cnt_d = tick_cnt_q + TW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cd_q       <= 2'd0;
      l1_q       <= 3'd0;
      l2_q       <= 3'd0;
      win_q      <= 2'd0;
      sec_q      <= 10'd0;
      tick_cnt_q <= '0;
      chk1_q     <= 1'b0;
      chk2_q     <= 1'b0;
      fin1_q     <= 1'b0;
      fin2_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cd_q       <= cd_d;
      l1_q       <= l1_d;
      l2_q       <= l2_d;
      win_q      <= win_d;
      sec_q      <= sec_d;
      tick_cnt_q <= tick_cnt_d;
      chk1_q     <= chk1_d;
      chk2_q     <= chk2_d;
      fin1_q     <= fin1_d;
      fin2_q     <= fin2_d;
    end
  end

  assign state     = state_q;
  assign countdown = cd_q;
  assign p1_lap    = l1_q;
  assign p2_lap    = l2_q;
  assign winner    = win_q;
  assign race_sec  = sec_q;

endmodule

// File: tb/tb_race_sequencer.sv
// Directed bench for race_sequencer: stimulus queues per-cycle expected outputs, a negedge monitor compares them.
module tb_race_sequencer;

  logic       clk, rst, start;
  logic [9:0] p1_x, p1_y, p2_x, p2_y;
  logic [2:0] state, p1_lap, p2_lap;
  logic [1:0] countdown, winner;
  logic [9:0] race_sec;

  race_sequencer #(.TICKS_PER_SEC(4), .LAPS(3)) dut (
    .clk(clk), .rst(rst), .start(start),
    .p1_x(p1_x), .p1_y(p1_y), .p2_x(p2_x), .p2_y(p2_y),
    .state(state), .countdown(countdown), .p1_lap(p1_lap), .p2_lap(p2_lap),
    .winner(winner), .race_sec(race_sec)
  );

  typedef struct {
    int         cyc;
    string      tag;
    logic [2:0] st;
    logic [1:0] cd;
    logic [2:0] l1;
    logic [2:0] l2;
    logic [1:0] w;
    logic [9:0] sec;
  } exp_t;

  exp_t  q[$];
  int    cyc = 0;
  int    checks = 0;
  int    passes = 0;
  int    race_r = 0;
  bit    sec_run = 0;
  string phase = "reset";
  logic [2:0] e_st = 3'd0;
  logic [1:0] e_cd = 2'd0;
  logic [2:0] e_l1 = 3'd0;
  logic [2:0] e_l2 = 3'd0;
  logic [1:0] e_w = 2'd0;
  logic [9:0] e_sec = 10'd0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops the expectation stamped for the current cycle and compares.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc < cyc) begin
      checks++;
      $display("FAIL %s: expectation for cycle %0d never compared", q[0].tag, q[0].cyc);
      void'(q.pop_front());
    end
    if (q.size() > 0 && q[0].cyc == cyc) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (state === e.st && countdown === e.cd && p1_lap === e.l1 && p2_lap === e.l2 &&
          winner === e.w && race_sec === e.sec)
        passes++;
      else
        $display("FAIL %s cyc%0d: got st=%0d cd=%0d l1=%0d l2=%0d w=%0d sec=%0d want st=%0d cd=%0d l1=%0d l2=%0d w=%0d sec=%0d",
                 e.tag, cyc, state, countdown, p1_lap, p2_lap, winner, race_sec,
                 e.st, e.cd, e.l1, e.l2, e.w, e.sec);
    end
  end

  task automatic step();
    exp_t e;
    if (sec_run) e_sec = 10'((cyc + 1 - race_r) / 4);
    e.cyc = cyc + 1; e.tag = phase; e.st = e_st; e.cd = e_cd;
    e.l1 = e_l1; e.l2 = e_l2; e.w = e_w; e.sec = e_sec;
    q.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic clear_exp();
    e_st = 3'd0; e_cd = 2'd0; e_l1 = 3'd0; e_l2 = 3'd0; e_w = 2'd0; e_sec = 10'd0;
    sec_run = 0;
  endtask

  // Start pulse from IDLE through to the first RACING cycle; poke repeats start mid-countdown.
  task automatic do_countdown(input bit poke);
    phase = "countdown";
    start = 1'b1; clear_exp(); e_st = 3'd1; e_cd = 2'd3;
    step();
    start = 1'b0;
    steps(3);
    e_cd = 2'd2; step();
    if (poke) start = 1'b1;
    step();
    start = 1'b0;
    steps(2);
    e_cd = 2'd1; steps(4);
    phase = "race_entry";
    e_st = 3'd4; e_cd = 2'd0; race_r = cyc + 1; sec_run = 1;
    step();
  endtask

  // Checkpoint, leave, re-enter finish box for the selected players.
  task automatic lap(input bit a, input bit b);
    if (a) begin p1_x = 10'd160; p1_y = 10'd40; end
    if (b) begin p2_x = 10'd160; p2_y = 10'd40; end
    step();
    if (a) begin p1_x = 10'd200; p1_y = 10'd200; end
    if (b) begin p2_x = 10'd200; p2_y = 10'd200; end
    step();
    if (a) begin p1_x = 10'd15; p1_y = 10'd125; e_l1 = e_l1 + 3'd1; end
    if (b) begin p2_x = 10'd15; p2_y = 10'd125; e_l2 = e_l2 + 3'd1; end
    if (e_l1 == 3'd3 && e_l2 == 3'd3) e_w = 2'd3;
    else if (e_l1 == 3'd3)            e_w = 2'd1;
    else if (e_l2 == 3'd3)            e_w = 2'd2;
    if (e_w != 2'd0) e_st = 3'd5;
    step();
    if (e_w != 2'd0) sec_run = 0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0;
    p1_x = 10'd15; p1_y = 10'd125; p2_x = 10'd15; p2_y = 10'd125;
    steps(2);
    rst = 1'b0;
    phase = "idle";
    steps(20);

    do_countdown(0);

    phase = "no_chk_reentry";
    p1_x = 10'd200; p1_y = 10'd200; step();
    p1_x = 10'd15;  p1_y = 10'd125; step();
    steps(3);
    phase = "p1_lap";
    lap(1, 0);
    phase = "p1_hold";
    steps(50);

    phase = "p2_win";
    lap(0, 1);
    lap(0, 1);
    lap(0, 1);
    phase = "freeze";
    p1_x = 10'd160; p1_y = 10'd40;  step();
    p1_x = 10'd200; p1_y = 10'd200; step();
    p1_x = 10'd15;  p1_y = 10'd125; step();
    steps(6);
    phase = "finish_to_idle";
    start = 1'b1; clear_exp(); step();
    start = 1'b0; steps(3);

    do_countdown(0);
    phase = "tie";
    lap(1, 1);
    lap(1, 1);
    lap(1, 1);
    steps(2);
    phase = "tie_to_idle";
    start = 1'b1; clear_exp(); step();
    start = 1'b0; steps(2);

    do_countdown(1);
    phase = "mid_race";
    lap(1, 0);
    lap(1, 0);
    do step(); while (e_sec != 10'd7);
    phase = "mid_race_reset";
    rst = 1'b1; clear_exp(); step();
    rst = 1'b0;
    phase = "after_reset";
    steps(3);

    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (q.size() == 0) passes++;
    else $display("FAIL drain: got %0d pending expectations, want 0", q.size());
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
